// File: rtl/adc_cmd_arbiter_if.sv
// Command/response bundle between the two ADC requesters, the arbiter and the adc_core port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface adc_cmd_arbiter_if;
  logic        A_C_Valid;
  logic [4:0]  A_C_Channel;
  logic        A_C_Ready;
  logic        B_C_Valid;
  logic [4:0]  B_C_Channel;
  logic        B_C_Ready;

  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready;

  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;

  logic        A_R_Valid;
  logic [4:0]  A_R_Channel;
  logic [11:0] A_R_Data;
  logic        B_R_Valid;
  logic [4:0]  B_R_Channel;
  logic [11:0] B_R_Data;

  modport slave (
    input  A_C_Valid, A_C_Channel, B_C_Valid, B_C_Channel,
    input  ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data,
    output A_C_Ready, B_C_Ready,
    output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    output A_R_Valid, A_R_Channel, A_R_Data,
    output B_R_Valid, B_R_Channel, B_R_Data
  );

  modport master (
    output A_C_Valid, A_C_Channel, B_C_Valid, B_C_Channel,
    output ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data,
    input  A_C_Ready, B_C_Ready,
    input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    input  A_R_Valid, A_R_Channel, A_R_Data,
    input  B_R_Valid, B_R_Channel, B_R_Data
  );
endinterface

// File: rtl/adc_cmd_arbiter.sv
// Round-robin sharing of the MAX10 ADC command port between two requesters, with a tag FIFO
// that steers each response back to whoever issued the matching command.
//
// state     | meaning
// ST_OPEN_A | no command stalled, A wins a tie
// ST_OPEN_B | no command stalled, B wins a tie
// ST_LOCK_A | A's command offered but not yet accepted; grant held on A
// ST_LOCK_B | B's command offered but not yet accepted; grant held on B
module adc_cmd_arbiter #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  adc_cmd_arbiter_if.slave     bus,
  output logic [CNT_WIDTH-1:0] Pending,
  output logic                 Err_Orphan,
  output logic                 Err_Mismatch
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  typedef enum logic [1:0] {ST_OPEN_A, ST_OPEN_B, ST_LOCK_A, ST_LOCK_B} state_t;

  typedef struct packed {
    logic       owner;
    logic [4:0] channel;
  } tag_t;

  state_t        state;
  tag_t          tag_mem [DEPTH];
  tag_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          eligible;
  logic          fifo_empty;
  logic          grant_b;
  logic          cmd_valid;
  logic          push;
  logic          pop;

  assign eligible   = (Pending < FULL_CNT);
  assign fifo_empty = (Pending == '0);
  assign head       = tag_mem[rd_ptr];

  always_comb begin
    grant_b = 1'b0;
    case (state)
      ST_LOCK_A: grant_b = 1'b0;
      ST_LOCK_B: grant_b = 1'b1;
      ST_OPEN_A: grant_b = bus.B_C_Valid && !bus.A_C_Valid;
      ST_OPEN_B: grant_b = !(bus.A_C_Valid && !bus.B_C_Valid);
      default:   grant_b = 1'b0;
    endcase
  end

  // Gated by RESETn so nothing is offered to the ADC while reset is held.
  assign cmd_valid = RESETn && eligible && (grant_b ? bus.B_C_Valid : bus.A_C_Valid);
  assign push      = cmd_valid && bus.ADC_C_Ready;
  assign pop       = bus.ADC_R_Valid && !fifo_empty;

  assign bus.ADC_C_Valid   = cmd_valid;
  assign bus.ADC_C_Channel = grant_b ? bus.B_C_Channel : bus.A_C_Channel;
  assign bus.ADC_C_SOP     = 1'b1;
  assign bus.ADC_C_EOP     = 1'b1;
  assign bus.A_C_Ready     = push && !grant_b;
  assign bus.B_C_Ready     = push && grant_b;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_OPEN_A;
    end else if (push) begin
      state <= grant_b ? ST_OPEN_A : ST_OPEN_B;
    end else if (cmd_valid) begin
      state <= grant_b ? ST_LOCK_B : ST_LOCK_A;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      tag_mem[wr_ptr] <= '{owner: grant_b, channel: bus.ADC_C_Channel};
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      Pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   Pending <= Pending + CNT_WIDTH'(1);
        2'b01:   Pending <= Pending - CNT_WIDTH'(1);
        default: Pending <= Pending;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      bus.A_R_Valid   <= 1'b0;
      bus.A_R_Channel <= '0;
      bus.A_R_Data    <= '0;
      bus.B_R_Valid   <= 1'b0;
      bus.B_R_Channel <= '0;
      bus.B_R_Data    <= '0;
      Err_Orphan      <= 1'b0;
      Err_Mismatch    <= 1'b0;
    end else begin
      bus.A_R_Valid <= pop && !head.owner;
      bus.B_R_Valid <= pop && head.owner;
      Err_Orphan    <= bus.ADC_R_Valid && fifo_empty;
      Err_Mismatch  <= pop && (bus.ADC_R_Channel != head.channel);
      if (pop && !head.owner) begin
        bus.A_R_Channel <= bus.ADC_R_Channel;
        bus.A_R_Data    <= bus.ADC_R_Data;
      end
      if (pop && head.owner) begin
        bus.B_R_Channel <= bus.ADC_R_Channel;
        bus.B_R_Data    <= bus.ADC_R_Data;
      end
    end
  end

endmodule

// File: tb/tb_adc_cmd_arbiter.sv
// Bench for adc_cmd_arbiter: fixed vector table, hand-written lock/reset/error sequences,
// then constrained-random traffic checked against a queue-based reference model.
module tb_adc_cmd_arbiter;
  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = 3;

  logic                 CLK = 1'b0;
  logic                 RESETn = 1'b0;
  logic [CNT_WIDTH-1:0] Pending;
  logic                 Err_Orphan;
  logic                 Err_Mismatch;
  int                   total = 0;
  int                   bad = 0;

  adc_cmd_arbiter_if bus();

  adc_cmd_arbiter #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .bus          (bus),
    .Pending      (Pending),
    .Err_Orphan   (Err_Orphan),
    .Err_Mismatch (Err_Mismatch)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          av;  logic [4:0] ach;
    bit          bv;  logic [4:0] bch;
    bit          rdy;
    bit          rv;  logic [4:0] rch; logic [11:0] rd;
    bit          e_cv; logic [4:0] e_cch; bit e_ard; bit e_brd;
    int          e_pend; bit e_arv; bit e_brv; logic [11:0] e_rd;
    bit          e_orph; bit e_mis;
  } vec_t;

  typedef struct packed {
    logic       owner;
    logic [4:0] ch;
  } tag_t;

  vec_t tbl[18];
  tag_t mq[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] ach, input bit bv, input logic [4:0] bch,
                       input bit rdy, input bit rv, input logic [4:0] rch, input logic [11:0] rd);
    bus.A_C_Valid     = av;
    bus.A_C_Channel   = ach;
    bus.B_C_Valid     = bv;
    bus.B_C_Channel   = bch;
    bus.ADC_C_Ready   = rdy;
    bus.ADC_R_Valid   = rv;
    bus.ADC_R_Channel = rch;
    bus.ADC_R_Data    = rd;
  endtask

  task automatic chk_cmd(input string tag, input bit cv, input logic [4:0] ch, input bit ard, input bit brd);
    chk({tag, " ADC_C_Valid"}, int'(bus.ADC_C_Valid), int'(cv));
    if (cv) chk({tag, " ADC_C_Channel"}, int'(bus.ADC_C_Channel), int'(ch));
    chk({tag, " A_C_Ready"}, int'(bus.A_C_Ready), int'(ard));
    chk({tag, " B_C_Ready"}, int'(bus.B_C_Ready), int'(brd));
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    RESETn = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Rows: inputs | expected command side | expected state after the edge.
    tbl[0]  = '{1, 5'd1, 0, 5'd0,  1, 0, 5'd0,  12'h000, 1, 5'd1,  1, 0, 1, 0, 0, 12'h000, 0, 0};
    tbl[1]  = '{0, 5'd0, 0, 5'd0,  0, 1, 5'd1,  12'h5A3, 0, 5'd0,  0, 0, 0, 1, 0, 12'h5A3, 0, 0};
    tbl[2]  = '{1, 5'd2, 1, 5'd17, 1, 0, 5'd0,  12'h000, 1, 5'd17, 0, 1, 1, 0, 0, 12'h000, 0, 0};
    tbl[3]  = '{1, 5'd2, 1, 5'd17, 1, 0, 5'd0,  12'h000, 1, 5'd2,  1, 0, 2, 0, 0, 12'h000, 0, 0};
    tbl[4]  = '{1, 5'd2, 1, 5'd17, 1, 1, 5'd17, 12'h111, 1, 5'd17, 0, 1, 2, 0, 1, 12'h111, 0, 0};
    tbl[5]  = '{1, 5'd2, 1, 5'd17, 1, 1, 5'd2,  12'h222, 1, 5'd2,  1, 0, 2, 1, 0, 12'h222, 0, 0};
    tbl[6]  = '{1, 5'd2, 1, 5'd17, 1, 1, 5'd17, 12'h333, 1, 5'd17, 0, 1, 2, 0, 1, 12'h333, 0, 0};
    tbl[7]  = '{1, 5'd2, 1, 5'd17, 1, 0, 5'd0,  12'h000, 1, 5'd2,  1, 0, 3, 0, 0, 12'h000, 0, 0};
    tbl[8]  = '{1, 5'd2, 1, 5'd17, 1, 0, 5'd0,  12'h000, 1, 5'd17, 0, 1, 4, 0, 0, 12'h000, 0, 0};
    tbl[9]  = '{1, 5'd2, 0, 5'd0,  1, 0, 5'd0,  12'h000, 0, 5'd0,  0, 0, 4, 0, 0, 12'h000, 0, 0};
    tbl[10] = '{1, 5'd2, 0, 5'd0,  1, 1, 5'd2,  12'h444, 0, 5'd0,  0, 0, 3, 1, 0, 12'h444, 0, 0};
    tbl[11] = '{1, 5'd2, 0, 5'd0,  1, 0, 5'd0,  12'h000, 1, 5'd2,  1, 0, 4, 0, 0, 12'h000, 0, 0};
    tbl[12] = '{0, 5'd0, 0, 5'd0,  0, 1, 5'd5,  12'h0AB, 0, 5'd0,  0, 0, 3, 0, 1, 12'h0AB, 0, 1};
    tbl[13] = '{0, 5'd0, 0, 5'd0,  0, 1, 5'd2,  12'h0CD, 0, 5'd0,  0, 0, 2, 1, 0, 12'h0CD, 0, 0};
    tbl[14] = '{0, 5'd0, 0, 5'd0,  0, 1, 5'd17, 12'h0EF, 0, 5'd0,  0, 0, 1, 0, 1, 12'h0EF, 0, 0};
    tbl[15] = '{0, 5'd0, 0, 5'd0,  0, 1, 5'd2,  12'h101, 0, 5'd0,  0, 0, 0, 1, 0, 12'h101, 0, 0};
    tbl[16] = '{0, 5'd0, 0, 5'd0,  0, 1, 5'd9,  12'h202, 0, 5'd0,  0, 0, 0, 0, 0, 12'h000, 1, 0};
    tbl[17] = '{0, 5'd0, 0, 5'd0,  0, 0, 5'd0,  12'h000, 0, 5'd0,  0, 0, 0, 0, 0, 12'h000, 0, 0};

    // Reset state, with A requesting while reset is held.
    drive(1'b1, 5'd7, 1'b0, '0, 1'b1, 1'b0, '0, '0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst ADC_C_Valid", int'(bus.ADC_C_Valid), 0);
    chk("rst A_C_Ready", int'(bus.A_C_Ready), 0);
    chk("rst Pending", int'(Pending), 0);
    chk("rst A_R_Valid", int'(bus.A_R_Valid), 0);
    chk("rst B_R_Valid", int'(bus.B_R_Valid), 0);
    chk("rst Err_Orphan", int'(Err_Orphan), 0);
    chk("rst Err_Mismatch", int'(Err_Mismatch), 0);
    chk("SOP tie", int'(bus.ADC_C_SOP), 1);
    chk("EOP tie", int'(bus.ADC_C_EOP), 1);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].av, tbl[i].ach, tbl[i].bv, tbl[i].bch, tbl[i].rdy, tbl[i].rv, tbl[i].rch, tbl[i].rd);
      @(negedge CLK);
      chk_cmd(tag, tbl[i].e_cv, tbl[i].e_cch, tbl[i].e_ard, tbl[i].e_brd);
      @(posedge CLK);
      #1;
      chk({tag, " Pending"}, int'(Pending), tbl[i].e_pend);
      chk({tag, " A_R_Valid"}, int'(bus.A_R_Valid), int'(tbl[i].e_arv));
      chk({tag, " B_R_Valid"}, int'(bus.B_R_Valid), int'(tbl[i].e_brv));
      chk({tag, " Err_Orphan"}, int'(Err_Orphan), int'(tbl[i].e_orph));
      chk({tag, " Err_Mismatch"}, int'(Err_Mismatch), int'(tbl[i].e_mis));
      if (tbl[i].e_arv) begin
        chk({tag, " A_R_Data"}, int'(bus.A_R_Data), int'(tbl[i].e_rd));
        chk({tag, " A_R_Channel"}, int'(bus.A_R_Channel), int'(tbl[i].rch));
      end
      if (tbl[i].e_brv) begin
        chk({tag, " B_R_Data"}, int'(bus.B_R_Data), int'(tbl[i].e_rd));
        chk({tag, " B_R_Channel"}, int'(bus.B_R_Channel), int'(tbl[i].rch));
      end
    end

    // Lock: A stalls three cycles, B (which now has priority) arrives meanwhile.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd3, (c > 0), 5'd20, 1'b0, 1'b0, '0, '0);
      @(negedge CLK);
      chk_cmd($sformatf("lock%0d", c), 1'b1, 5'd3, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
    end
    drive(1'b1, 5'd3, 1'b1, 5'd20, 1'b1, 1'b0, '0, '0);
    @(negedge CLK);
    chk_cmd("lock accept", 1'b1, 5'd3, 1'b1, 1'b0);
    @(posedge CLK);
    #1;
    drive(1'b0, '0, 1'b1, 5'd20, 1'b1, 1'b0, '0, '0);
    @(negedge CLK);
    chk_cmd("lock next B", 1'b1, 5'd20, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    chk("lock Pending", int'(Pending), 2);

    // Asynchronous reset mid-operation, then a stray response.
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    chk("async Pending", int'(Pending), 0);
    chk("async A_R_Data", int'(bus.A_R_Data), 0);
    chk("async B_R_Data", int'(bus.B_R_Data), 0);
    chk("async A_R_Channel", int'(bus.A_R_Channel), 0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 5'd3, 12'h007);
    @(posedge CLK);
    #1;
    chk("post-rst Err_Orphan", int'(Err_Orphan), 1);
    chk("post-rst A_R_Valid", int'(bus.A_R_Valid), 0);
    chk("post-rst B_R_Valid", int'(bus.B_R_Valid), 0);
    chk("post-rst Pending", int'(Pending), 0);

    // Mismatch: tag ch 3, response ch 4.
    drive(1'b1, 5'd3, 1'b0, '0, 1'b1, 1'b0, '0, '0);
    @(posedge CLK);
    #1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 5'd4, 12'h09C);
    @(posedge CLK);
    #1;
    chk("mis Err_Mismatch", int'(Err_Mismatch), 1);
    chk("mis A_R_Valid", int'(bus.A_R_Valid), 1);
    chk("mis A_R_Data", int'(bus.A_R_Data), 12'h09C);
    chk("mis A_R_Channel", int'(bus.A_R_Channel), 4);
    chk("mis Err_Orphan", int'(Err_Orphan), 0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(posedge CLK);
    #1;
    chk("mis pulse end", int'(Err_Mismatch), 0);
    chk("mis rv end", int'(bus.A_R_Valid), 0);
    chk("mis data held", int'(bus.A_R_Data), 12'h09C);

    // Random traffic against a queue-level model.
    do_reset();
    begin
      int          m_prio, m_lock, own;
      bit          a_hold, b_hold, av, bv, rdy, rv, ecv, hs, e_arv, e_brv, e_orph, e_mis;
      logic [4:0]  ach, bch, rch, ech, m_arc, m_brc;
      logic [11:0] rd, m_ard, m_brd;
      tag_t        t;
      mq.delete();
      m_prio = 0; m_lock = -1;
      a_hold = 0; b_hold = 0; av = 0; bv = 0; ach = '0; bch = '0;
      m_arc = '0; m_brc = '0; m_ard = '0; m_brd = '0;
      for (int i = 0; i < 800; i++) begin
        if (!a_hold) begin av = 1'($urandom_range(0, 1)); ach = 5'($urandom_range(0, 31)); end
        if (!b_hold) begin bv = 1'($urandom_range(0, 1)); bch = 5'($urandom_range(0, 31)); end
        rdy = ($urandom_range(0, 9) < 7);
        rv  = ($urandom_range(0, 9) < 4);
        if (mq.size() > 0 && $urandom_range(0, 7) != 0) rch = mq[0].ch;
        else rch = 5'($urandom_range(0, 31));
        rd = 12'($urandom_range(0, 4095));
        drive(av, ach, bv, bch, rdy, rv, rch, rd);

        if (m_lock >= 0) own = m_lock;
        else if (av && !bv) own = 0;
        else if (bv && !av) own = 1;
        else if (av && bv) own = m_prio;
        else own = -1;
        ecv = (mq.size() < DEPTH) && (own >= 0) && ((own == 1) ? bv : av);
        ech = (own == 1) ? bch : ach;
        hs  = ecv && rdy;

        @(negedge CLK);
        chk_cmd($sformatf("rnd%0d", i), ecv, ech, hs && own == 0, hs && own == 1);

        e_arv = 0; e_brv = 0; e_orph = 0; e_mis = 0;
        if (rv) begin
          if (mq.size() == 0) e_orph = 1;
          else begin
            t = mq.pop_front();
            e_mis = (t.ch != rch);
            if (t.owner) begin e_brv = 1; m_brc = rch; m_brd = rd; end
            else begin e_arv = 1; m_arc = rch; m_ard = rd; end
          end
        end
        if (hs) begin
          t.owner = (own == 1);
          t.ch = ech;
          mq.push_back(t);
          m_prio = 1 - own;
          m_lock = -1;
        end else if (ecv) begin
          m_lock = own;
        end
        a_hold = av && !(hs && own == 0);
        b_hold = bv && !(hs && own == 1);

        @(posedge CLK);
        #1;
        chk("rnd Pending", int'(Pending), mq.size());
        chk("rnd A_R_Valid", int'(bus.A_R_Valid), int'(e_arv));
        chk("rnd B_R_Valid", int'(bus.B_R_Valid), int'(e_brv));
        chk("rnd A_R_Channel", int'(bus.A_R_Channel), int'(m_arc));
        chk("rnd A_R_Data", int'(bus.A_R_Data), int'(m_ard));
        chk("rnd B_R_Channel", int'(bus.B_R_Channel), int'(m_brc));
        chk("rnd B_R_Data", int'(bus.B_R_Data), int'(m_brd));
        chk("rnd Err_Orphan", int'(Err_Orphan), int'(e_orph));
        chk("rnd Err_Mismatch", int'(Err_Mismatch), int'(e_mis));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_cmd_arbiter.md
Name: adc_cmd_arbiter

Overview:
- Shares the single MAX10 modular ADC Avalon-ST command/response port between two independent requesters:
  - A: the software-controlled mfp_adc_max10_core sequencer.
  - B: a hardware periodic-sampling scheduler.
- Arbitrates command slots round-robin and records the owner and channel of every in-flight conversion in a tag FIFO.
- Routes each ADC response back to the requester that issued it.
- Sits between the requesters and the adc_core IP, in the CLK domain.

Parameters:
- DEPTH, 4, max outstanding commands (tag FIFO entries, power of two, 2..16).
- CNT_WIDTH, 3, width of the outstanding counter; must hold the value DEPTH.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESETn  in  1  asynchronous active-low reset.
- A_C_Valid  in  1  requester A command valid.
- A_C_Channel  in  5  requester A channel.
- A_C_Ready  out  1  requester A command accepted this cycle.
- B_C_Valid  in  1  requester B command valid.
- B_C_Channel  in  5  requester B channel.
- B_C_Ready  out  1  requester B command accepted this cycle.
- ADC_C_Valid  out  1  command valid to ADC.
- ADC_C_Channel  out  5  command channel to ADC.
- ADC_C_SOP  out  1  tied 1 (single-beat packets).
- ADC_C_EOP  out  1  tied 1.
- ADC_C_Ready  in  1  ADC command ready.
- ADC_R_Valid  in  1  ADC response valid.
- ADC_R_Channel  in  5  ADC response channel.
- ADC_R_Data  in  12  ADC response sample.
- A_R_Valid  out  1  response to A, one-cycle pulse.
- A_R_Channel  out  5  response channel to A.
- A_R_Data  out  12  response data to A.
- B_R_Valid, B_R_Channel, B_R_Data  out  1/5/12  same, for requester B.
- Pending  out  CNT_WIDTH  outstanding command count.
- Err_Orphan  out  1  pulse: response arrived with tag FIFO empty.
- Err_Mismatch  out  1  pulse: response channel differs from the stored tag channel.

Behaviour:
- Reset (asynchronous, RESETn=0):
  - Registered outputs = 0: A_R_*, B_R_*, Pending, Err_*.
  - FIFO emptied; lock cleared; priority pointer = A.
  - ADC_C_Valid = 0.
- Requester rule: a requester holds Valid and Channel stable until its Ready is seen high.
- Eligibility: a command may be offered only when registered Pending < DEPTH. At Pending == DEPTH:
  - ADC_C_Valid = 0 and both C_Ready = 0.
  - No push occurs even if a pop happens in the same cycle; the freed slot is usable the next cycle.
- Arbitration, when unlocked and eligible:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - Grant is combinational: ADC_C_Valid = granted Valid; ADC_C_Channel = granted Channel.
- Lock: if ADC_C_Valid=1 and ADC_C_Ready=0, the grant register locks to the current requester. The grant cannot switch until the handshake completes, even if the other requester has priority.
- Handshake (ADC_C_Valid & ADC_C_Ready):
  - Granted requester sees C_Ready=1 combinationally in the same cycle.
  - Push {owner, channel} into the FIFO.
  - Pointer set to the non-granted requester; lock cleared.
  - Non-granted C_Ready is always 0.
- Response (ADC_R_Valid), FIFO non-empty:
  - Pop the head entry.
  - Next cycle: owner's R_Valid=1 with R_Channel=ADC_R_Channel and R_Data=ADC_R_Data; the other requester's R_Valid=0. Latency is exactly 1 cycle.
  - If ADC_R_Channel ≠ stored channel: Err_Mismatch=1 for that cycle; data is still delivered to the owner.
- Response, FIFO empty: data dropped, no R_Valid; Err_Orphan=1 for one cycle; Pending stays 0.
- Pending: +1 on push, −1 on pop, unchanged on simultaneous push and pop. Never wraps; saturation is prevented by the eligibility rule.
- FIFO pointers: log2(DEPTH) bits, natural wrap-around. Empty/full derived from Pending.
- Back-to-back responses, one per cycle: each produces its own one-cycle R_Valid pulse, in FIFO order.
- R_Channel/R_Data retain their last value when R_Valid=0.
- Reset asserted mid-operation discards all tags. Responses arriving after reset release are reported as orphans.

Test Plan:
- Single requester: A requests ch 1; ADC_C_Ready=1 → ADC_C_Channel=1 and A_C_Ready=1 same cycle, Pending=1. Then ADC_R_Valid, ch 1, data 0x5A3 → next cycle A_R_Valid=1, A_R_Data=0x5A3, B_R_Valid=0, Pending=0.
- Contention: A (ch 2) and B (ch 17) held valid continuously with ADC_C_Ready=1 → grants alternate A,B,A,B; channels issued 2,17,2,17; responses returned in order go to A,B,A,B.
- Lock: A valid, ADC_C_Ready=0 for 3 cycles, B asserted in cycle 2 → ADC_C_Channel stays A's for all 3 cycles. Ready=1 in cycle 4 grants A; B is granted next.
- Full: DEPTH=4, four commands accepted with no responses → Pending=4, ADC_C_Valid=0 despite A valid. One response → Pending=3, new command issued the following cycle.
- Errors: ADC_R_Valid with FIFO empty → Err_Orphan pulse, no R_Valid. Tag ch 3 but response ch 4 → Err_Mismatch pulse, data delivered to the owner.
- Reset mid-operation: Pending=2, RESETn=0 asynchronously → all outputs 0 immediately. A later response → Err_Orphan.
